// File: rtl/spi_master.sv
// SPI mode-0 master: one byte per transfer, MSB first, SCLK half-period = CLK_DIV clk cycles.
// Accepted start to done is 18*CLK_DIV cycles; start is ignored while busy_o is high.
module spi_master #(
  parameter int CLK_DIV = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [7:0] tx_data_i,
  output logic [7:0] rx_data_o,
  output logic       done_o,
  output logic       busy_o,
  output logic       sclk_o,
  output logic       mosi_o,
  input  logic       miso_i,
  output logic       ss_n_o
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    CLK_LO,
    CLK_HI,
    STOP
  } state_e;

  localparam logic [9:0] HALF_LAST = 10'(CLK_DIV - 1);

  state_e     state_q;
  logic [9:0] half_cnt_q;
  logic [9:0] half_cnt_d;
  logic       half_end;
  logic [2:0] bit_cnt_q;
  logic [7:0] tx_shift_q;
  logic [7:0] rx_shift_q;
  logic       stop_tail_q;

  always_comb begin
    half_end   = (half_cnt_q == HALF_LAST);
    half_cnt_d = half_end ? 10'd0 : half_cnt_q + 10'd1;
    if (state_q == IDLE) begin
      half_cnt_d = 10'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      half_cnt_q  <= 10'd0;
      bit_cnt_q   <= 3'd0;
      tx_shift_q  <= 8'h00;
      rx_shift_q  <= 8'h00;
      stop_tail_q <= 1'b0;
      rx_data_o   <= 8'h00;
      done_o      <= 1'b0;
      busy_o      <= 1'b0;
      sclk_o      <= 1'b0;
      mosi_o      <= 1'b0;
      ss_n_o      <= 1'b1;
    end else begin
      done_o     <= 1'b0;
      half_cnt_q <= half_cnt_d;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            tx_shift_q  <= {tx_data_i[6:0], 1'b0};
            rx_shift_q  <= 8'h00;
            mosi_o      <= tx_data_i[7];
            ss_n_o      <= 1'b0;
            busy_o      <= 1'b1;
            bit_cnt_q   <= 3'd0;
            stop_tail_q <= 1'b0;
            state_q     <= SETUP;
          end
        end
        SETUP: begin
          if (half_end) begin
            sclk_o     <= 1'b1;
            rx_shift_q <= {rx_shift_q[6:0], miso_i};
            state_q    <= CLK_HI;
          end
        end
        CLK_HI: begin
          if (half_end) begin
            sclk_o <= 1'b0;
            if (bit_cnt_q == 3'd7) begin
              state_q <= STOP;
            end else begin
              bit_cnt_q  <= bit_cnt_q + 3'd1;
              mosi_o     <= tx_shift_q[7];
              tx_shift_q <= {tx_shift_q[6:0], 1'b0};
              state_q    <= CLK_LO;
            end
          end
        end
        CLK_LO: begin
          if (half_end) begin
            sclk_o     <= 1'b1;
            rx_shift_q <= {rx_shift_q[6:0], miso_i};
            state_q    <= CLK_HI;
          end
        end
        STOP: begin
          // The final SCLK low half-period runs out before the select hold period starts.
          if (half_end) begin
            if (!stop_tail_q) begin
              stop_tail_q <= 1'b1;
            end else begin
              ss_n_o    <= 1'b1;
              mosi_o    <= 1'b0;
              rx_data_o <= rx_shift_q;
              done_o    <= 1'b1;
              busy_o    <= 1'b0;
              state_q   <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master at CLK_DIV=4: vector table, start-ignore, mid-transfer reset, back-to-back.
module tb_spi_master;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] tx_data;
  logic [7:0] rx_data;
  logic       done;
  logic       busy;
  logic       sclk;
  logic       mosi;
  logic       miso;
  logic       ss_n;

  logic       loopback = 1'b0;
  logic [7:0] slave_byte = 8'h00;
  logic [7:0] sl_sh = 8'h00;
  logic       sl_pss = 1'b1;
  logic       sl_psclk = 1'b0;

  assign miso = loopback ? mosi : sl_sh[7];

  spi_master #(.CLK_DIV(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start),
    .tx_data_i(tx_data),
    .rx_data_o(rx_data),
    .done_o   (done),
    .busy_o   (busy),
    .sclk_o   (sclk),
    .mosi_o   (mosi),
    .miso_i   (miso),
    .ss_n_o   (ss_n)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Slave model: first bit presented when select falls, next bit after each SCLK fall.
  always @(negedge clk) begin
    if (sl_pss && !ss_n) sl_sh = slave_byte;
    else if (!ss_n && sl_psclk && !sclk) sl_sh = {sl_sh[6:0], 1'b0};
    sl_pss   = ss_n;
    sl_psclk = sclk;
  end

  logic [7:0] exp_rx_q[$];
  logic [7:0] exp_tx_q[$];

  logic [7:0] mosi_acc = 8'h00;
  int         rise_cnt = 0;
  int         glitch = 0;
  int         t0 = 0;
  int         last_done = 0;
  int         ss_hi_run = 0;
  logic       b2b_mode = 1'b0;
  logic       b2b_seen = 1'b0;
  logic       p_busy = 1'b0, p_mosi = 1'b0, p_sclk = 1'b0, p_done = 1'b0;

  always @(negedge clk) begin
    logic [7:0] erx, etx;
    if (rst) begin
      rise_cnt = 0;
      mosi_acc = 8'h00;
      glitch   = 0;
    end else begin
      if (busy && !p_busy) begin
        if (b2b_mode && b2b_seen) chk("ss_high_gap", 32'(ss_hi_run), 32'd1);
        t0       = cyc;
        rise_cnt = 0;
        mosi_acc = 8'h00;
        glitch   = 0;
      end else if (mosi !== p_mosi && !(p_sclk && !sclk) && !done) begin
        glitch++;
      end
      if (sclk && !p_sclk) begin
        rise_cnt++;
        mosi_acc = {mosi_acc[6:0], mosi};
      end
      if (done) begin
        chk("done_width", 32'(p_done), 32'd0);
        if (exp_rx_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          erx = exp_rx_q.pop_front();
          etx = exp_tx_q.pop_front();
          chk("rx_data", 32'(rx_data), 32'(erx));
          chk("mosi_bits", 32'(mosi_acc), 32'(etx));
          chk("sclk_rises", 32'(rise_cnt), 32'd8);
          chk("latency", 32'(cyc - t0), 32'd72);
          chk("ss_n_at_done", 32'(ss_n), 32'd1);
          chk("busy_at_done", 32'(busy), 32'd0);
          chk("mosi_stable", 32'(glitch), 32'd0);
          if (b2b_mode && b2b_seen) chk("done_period", 32'(cyc - last_done), 32'd73);
          if (b2b_mode) b2b_seen = 1'b1;
        end
        last_done = cyc;
        done_cnt++;
      end
      ss_hi_run = ss_n ? ss_hi_run + 1 : 0;
    end
    p_busy = busy;
    p_mosi = mosi;
    p_sclk = sclk;
    p_done = done;
  end

  typedef struct {
    logic [7:0] tx;
    logic [7:0] sl;
    logic       loop;
    logic [7:0] exp_rx;
  } vec_t;

  task automatic wait_done(input int n, input int budget);
    int seen = 0;
    for (int c = 0; c < budget && seen < n; c++) begin
      @(negedge clk);
      if (done) seen++;
    end
    if (seen < n) chk("done_timeout", 32'(seen), 32'(n));
  endtask

  task automatic send(input logic [7:0] tx, input logic [7:0] sl, input logic lp, input logic [7:0] erx);
    loopback   = lp;
    slave_byte = sl;
    exp_rx_q.push_back(erx);
    exp_tx_q.push_back(tx);
    @(negedge clk);
    tx_data = tx;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int   dc;
    int   n;
    int   c;
    vecs[0] = '{tx: 8'hA5, sl: 8'h00, loop: 1'b1, exp_rx: 8'hA5};
    vecs[1] = '{tx: 8'h00, sl: 8'hC3, loop: 1'b0, exp_rx: 8'hC3};
    vecs[2] = '{tx: 8'h3C, sl: 8'h00, loop: 1'b1, exp_rx: 8'h3C};
    vecs[3] = '{tx: 8'h5A, sl: 8'h96, loop: 1'b0, exp_rx: 8'h96};
    vecs[4] = '{tx: 8'hFF, sl: 8'h00, loop: 1'b0, exp_rx: 8'h00};
    vecs[5] = '{tx: 8'h01, sl: 8'h80, loop: 1'b0, exp_rx: 8'h80};

    rst     = 1'b1;
    start   = 1'b0;
    tx_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_ss_n", 32'(ss_n), 32'd1);
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_mosi", 32'(mosi), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      send(vecs[i].tx, vecs[i].sl, vecs[i].loop, vecs[i].exp_rx);
      wait_done(1, 200);
      repeat (3) @(negedge clk);
      chk("rx_data_hold", 32'(rx_data), 32'(vecs[i].exp_rx));
    end

    // Start pulses with a new byte while busy must not disturb the transfer.
    send(8'h69, 8'h00, 1'b1, 8'h69);
    dc = done_cnt;
    repeat (8) @(negedge clk);
    tx_data = 8'hFF;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(1, 200);
    repeat (100) @(negedge clk);
    chk("single_done", 32'(done_cnt - dc), 32'd1);

    // Reset during the fifth SCLK high phase.
    send(8'h3C, 8'h00, 1'b1, 8'h3C);
    c = 0;
    while (rise_cnt < 5 && c < 200) begin
      @(posedge clk);
      c++;
    end
    chk("reach_rise5", 32'(rise_cnt >= 5), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_ss_n", 32'(ss_n), 32'd1);
    chk("midrst_sclk", 32'(sclk), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_rx_data", 32'(rx_data), 32'd0);
    exp_rx_q.delete();
    exp_tx_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    dc = done_cnt;
    repeat (100) @(negedge clk);
    chk("no_done_after_rst", 32'(done_cnt - dc), 32'd0);
    chk("rx_after_rst", 32'(rx_data), 32'd0);
    send(8'h81, 8'h00, 1'b1, 8'h81);
    wait_done(1, 200);

    // Start held high: three back-to-back transfers.
    repeat (4) @(negedge clk);
    b2b_mode = 1'b1;
    b2b_seen = 1'b0;
    loopback = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_rx_q.push_back(8'h96);
      exp_tx_q.push_back(8'h96);
    end
    tx_data = 8'h96;
    start   = 1'b1;
    n = 0;
    for (int k = 0; k < 400 && n < 3; k++) begin
      @(negedge clk);
      if (done) n++;
    end
    start = 1'b0;
    chk("b2b_done_count", 32'(n), 32'd3);
    repeat (100) @(negedge clk);
    b2b_mode = 1'b0;
    chk("b2b_queue_empty", 32'(exp_rx_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
